sigma_delta_modulator: RTL and testbench

- First-order pulse-density modulator; the transmit-side counterpart of the sigma-delta counter.
- Accepts a digital code `K` per frame over a valid/ready handshake and emits exactly `K` ones across `NUMBER_OF_SAMPLES` consecutive cycles on a 1-bit `pulse` stream.
- Ones are spread by error-feedback accumulation.
- Sits between a digital setpoint source and a sigma-delta counter (loopback/BIST) or an external 1-bit DAC.

---
 rtl/sigma_delta_pkg.sv | 34 +++
 rtl/sigma_delta_modulator_if.sv | 42 ++++
 rtl/sigma_delta_accumulator.sv | 57 +++++
 rtl/sigma_delta_modulator.sv | 107 ++++++++++
 tb/tb_sigma_delta_modulator.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/sigma_delta_pkg.sv
// ----------------------------------------------------------------------------
// sigma_delta_pkg
// Shared types and width helpers for the sigma-delta modulator/counter pair.
// Widths are functions of the frame length N so every user can size its
// own logic from its own NUMBER_OF_SAMPLES parameter.
// ----------------------------------------------------------------------------
package sigma_delta_pkg;

   typedef enum logic {
      SD_IDLE = 1'b0,
      SD_RUN  = 1'b1
   } sd_state_e;

   // code 0..N inclusive
   function automatic int code_w(input int n);
      return $clog2(n + 1);
   endfunction

   // acc + cq peaks at 2N-1
   function automatic int acc_w(input int n);
      return $clog2(2 * n);
   endfunction

   // sample index 0..N-1
   function automatic int cnt_w(input int n);
      return $clog2(n);
   endfunction

   localparam int SD_N_DEFAULT = 1000;
   localparam int CODE_W       = code_w(SD_N_DEFAULT);
   localparam int ACC_W        = acc_w(SD_N_DEFAULT);
   localparam int CNT_W        = cnt_w(SD_N_DEFAULT);

endpackage

// File: rtl/sigma_delta_modulator_if.sv
// ----------------------------------------------------------------------------
// sigma_delta_modulator_if
// Code handshake plus bitstream outputs of the modulator.
//   code/code_valid  : setpoint source -> modulator
//   code_ready       : modulator -> source
//   pulse            : 1-bit pulse-density stream
//   frame_start      : high during sample 0 of each frame
//   busy             : high while a frame is being emitted
// master = setpoint source / observer, slave = modulator.
// ----------------------------------------------------------------------------
interface sigma_delta_modulator_if
   import sigma_delta_pkg::*;
#(
   parameter int N = 1000
) ();

   logic [code_w(N)-1:0] code;
   logic                 code_valid;
   logic                 code_ready;
   logic                 pulse;
   logic                 frame_start;
   logic                 busy;

   modport master (
      output code,
      output code_valid,
      input  code_ready,
      input  pulse,
      input  frame_start,
      input  busy
   );

   modport slave (
      input  code,
      input  code_valid,
      output code_ready,
      output pulse,
      output frame_start,
      output busy
   );

endinterface

// File: rtl/sigma_delta_accumulator.sv
// ----------------------------------------------------------------------------
// sigma_delta_accumulator
// First-order error-feedback core: sum = acc + cq, fire when sum >= N,
// subtract N on fire. Over N enabled samples starting from acc = 0 this
// emits exactly cq ones and leaves acc back at 0.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_cq           : ones-per-frame for this sample (already clamped to N)
//   i_clear        : treat acc as 0 for this sample (first sample of frame)
//   i_enable       : compute a sample; when low, pulse and acc go to 0
//   o_pulse        : registered bitstream
// ----------------------------------------------------------------------------
module sigma_delta_accumulator
   import sigma_delta_pkg::*;
#(
   parameter int N = 1000
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic [code_w(N)-1:0] i_cq,
   input  logic                 i_clear,
   input  logic                 i_enable,
   output logic                 o_pulse
);

   localparam int AW = acc_w(N);
   localparam logic [AW-1:0] N_ACC = AW'(N);

   logic [AW-1:0] r_acc;
   logic          r_pulse;
   logic [AW-1:0] w_base;
   logic [AW-1:0] w_sum;
   logic          w_fire;
   logic [AW-1:0] w_acc_nxt;

   always_comb begin
      w_base    = i_clear ? '0 : r_acc;
      w_sum     = w_base + AW'(i_cq);
      w_fire    = (w_sum >= N_ACC);
      w_acc_nxt = w_fire ? (w_sum - N_ACC) : w_sum;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_acc   <= '0;
         r_pulse <= 1'b0;
      end else if (i_enable) begin
         r_acc   <= w_acc_nxt;
         r_pulse <= w_fire;
      end else begin
         r_acc   <= '0;
         r_pulse <= 1'b0;
      end
   end

   assign o_pulse = r_pulse;

endmodule

// File: rtl/sigma_delta_modulator.sv
// ----------------------------------------------------------------------------
// sigma_delta_modulator
// First-order pulse-density modulator. Accepts a code K per frame and emits
// exactly min(K, N) ones spread over N consecutive cycles on sd.pulse.
// Frames run back to back when a new code is accepted on the last sample.
//   i_clk, i_rst_n : clock, async active-low reset
//   sd (slave)     : code/code_valid/code_ready handshake,
//                    pulse/frame_start/busy outputs
// NUMBER_OF_SAMPLES must be >= 2.
// ----------------------------------------------------------------------------
module sigma_delta_modulator
   import sigma_delta_pkg::*;
#(
   parameter int NUMBER_OF_SAMPLES = 1000
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   sigma_delta_modulator_if.slave sd
);

   localparam int N  = NUMBER_OF_SAMPLES;
   localparam int QW = code_w(N);
   localparam int CW = cnt_w(N);
   localparam logic [CW-1:0] LAST   = CW'(N - 1);
   localparam logic [QW-1:0] N_CODE = QW'(N);

   sd_state_e     r_state, w_state_nxt;
   logic [CW-1:0] r_cnt, w_cnt_nxt;
   logic [QW-1:0] r_cq, w_cq_nxt;
   logic          r_frame_start;

   logic          w_last;
   logic          w_ready;
   logic          w_accept;
   logic [QW-1:0] w_cq_clamp;
   logic [QW-1:0] w_cq_use;
   logic          w_acc_en;
   logic          w_acc_clr;
   logic          w_pulse;

   // Ready depends only on state and counter so a source may wait on it
   // before raising valid without creating a combinational loop.
   always_comb begin
      w_last     = (r_cnt == LAST);
      w_ready    = (r_state == SD_IDLE) || w_last;
      w_accept   = w_ready && sd.code_valid;
      w_cq_clamp = (sd.code > N_CODE) ? N_CODE : sd.code;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_cq_nxt    = r_cq;
      w_acc_en    = 1'b0;
      w_acc_clr   = 1'b0;
      if (w_accept) begin
         // the accept edge itself produces sample 0
         w_state_nxt = SD_RUN;
         w_cnt_nxt   = '0;
         w_cq_nxt    = w_cq_clamp;
         w_acc_en    = 1'b1;
         w_acc_clr   = 1'b1;
      end else if (r_state == SD_RUN) begin
         if (w_last) begin
            w_state_nxt = SD_IDLE;
            w_cnt_nxt   = '0;
         end else begin
            w_cnt_nxt   = r_cnt + CW'(1);
            w_acc_en    = 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state       <= SD_IDLE;
         r_cnt         <= '0;
         r_cq          <= '0;
         r_frame_start <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_cnt         <= w_cnt_nxt;
         r_cq          <= w_cq_nxt;
         // registered with pulse so it marks sample 0 of the stream
         r_frame_start <= w_accept;
      end
   end

   // On the accept edge the freshly clamped code feeds the accumulator
   // directly; r_cq only becomes valid after that edge.
   assign w_cq_use = w_accept ? w_cq_clamp : r_cq;

   sigma_delta_accumulator #(.N(N)) u_acc (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_cq     (w_cq_use),
      .i_clear  (w_acc_clr),
      .i_enable (w_acc_en),
      .o_pulse  (w_pulse)
   );

   assign sd.code_ready  = w_ready;
   assign sd.pulse       = w_pulse;
   assign sd.frame_start = r_frame_start;
   assign sd.busy        = (r_state == SD_RUN);

endmodule

// File: tb/tb_sigma_delta_modulator.sv
// ----------------------------------------------------------------------------
// tb_sigma_delta_modulator
// Directed + random bench for the modulator at N=10 and N=1000.
// Reference: ideal sample k of a frame with cq ones is
// floor((k+1)*cq/N) - floor(k*cq/N); a frame's total is cq = min(code, N).
// ----------------------------------------------------------------------------
module tb_sigma_delta_modulator;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   sigma_delta_modulator_if #(.N(10))   if10 ();
   sigma_delta_modulator_if #(.N(1000)) if1k ();

   sigma_delta_modulator #(.NUMBER_OF_SAMPLES(10)) u10 (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .sd      (if10)
   );

   sigma_delta_modulator #(.NUMBER_OF_SAMPLES(1000)) u1k (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .sd      (if1k)
   );

   int n_err = 0;
   int n_chk = 0;

   function automatic int ref_bit(input int k, input int cq, input int n);
      return ((k + 1) * cq) / n - (k * cq) / n;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      @(negedge clk);
   endtask

   // Accept one code on the N=10 instance and check the whole frame.
   task automatic frame10(input int code, input int cq, input string tag);
      int ones;
      if10.code       = 4'(code);
      if10.code_valid = 1'b1;
      chk({tag, " ready_before"}, 32'(if10.code_ready), 1);
      tick();
      if10.code_valid = 1'b0;
      ones = 0;
      for (int k = 0; k < 10; k++) begin
         chk($sformatf("%s pulse[%0d]", tag, k), 32'(if10.pulse), ref_bit(k, cq, 10));
         chk($sformatf("%s fs[%0d]", tag, k), 32'(if10.frame_start), (k == 0) ? 1 : 0);
         chk($sformatf("%s busy[%0d]", tag, k), 32'(if10.busy), 1);
         chk($sformatf("%s ready[%0d]", tag, k), 32'(if10.code_ready), (k == 9) ? 1 : 0);
         ones += int'(if10.pulse);
         tick();
      end
      chk({tag, " ones"}, ones, cq);
      chk({tag, " busy_after"}, 32'(if10.busy), 0);
      chk({tag, " pulse_after"}, 32'(if10.pulse), 0);
      chk({tag, " ready_after"}, 32'(if10.code_ready), 1);
   endtask

   initial begin
      int ones, mism, fs1, code, cq;

      if10.code = '0;
      if10.code_valid = 1'b0;
      if1k.code = '0;
      if1k.code_valid = 1'b0;

      // reset state
      rst_n = 1'b0;
      tick();
      tick();
      chk("rst pulse", 32'(if10.pulse), 0);
      chk("rst fs", 32'(if10.frame_start), 0);
      chk("rst busy", 32'(if10.busy), 0);
      chk("rst ready", 32'(if10.code_ready), 1);
      chk("rst busy1k", 32'(if1k.busy), 0);
      rst_n = 1'b1;
      tick();

      // single frames incl. boundary codes and clamping
      frame10(3, 3, "k3");
      frame10(0, 0, "k0");
      frame10(10, 10, "k10");
      frame10(15, 10, "k15");

      // back-to-back: 3 then 7, code changes while ready=0 are ignored
      if10.code = 4'd3;
      if10.code_valid = 1'b1;
      tick();
      fs1 = cyc;
      for (int k = 0; k < 10; k++) begin
         if (k == 0) if10.code = 4'd7;
         chk($sformatf("b2b1 pulse[%0d]", k), 32'(if10.pulse), ref_bit(k, 3, 10));
         tick();
      end
      chk("b2b fs2", 32'(if10.frame_start), 1);
      chk("b2b busy2", 32'(if10.busy), 1);
      chk("b2b period", cyc - fs1, 10);
      if10.code_valid = 1'b0;
      ones = 0;
      for (int k = 0; k < 10; k++) begin
         chk($sformatf("b2b2 pulse[%0d]", k), 32'(if10.pulse), ref_bit(k, 7, 10));
         ones += int'(if10.pulse);
         tick();
      end
      chk("b2b2 ones", ones, 7);
      chk("b2b2 busy_after", 32'(if10.busy), 0);

      // mid-frame valid with a different code is ignored
      if10.code = 4'd2;
      if10.code_valid = 1'b1;
      tick();
      if10.code_valid = 1'b0;
      ones = 0;
      for (int k = 0; k < 10; k++) begin
         if (k == 4) begin
            if10.code = 4'd8;
            if10.code_valid = 1'b1;
            chk("mid ready", 32'(if10.code_ready), 0);
         end
         if (k == 5) if10.code_valid = 1'b0;
         ones += int'(if10.pulse);
         tick();
      end
      chk("mid ones", ones, 2);
      chk("mid busy_after", 32'(if10.busy), 0);

      // asynchronous reset at sample 5 of a code=5 frame
      if10.code = 4'd5;
      if10.code_valid = 1'b1;
      tick();
      if10.code_valid = 1'b0;
      for (int k = 0; k < 5; k++) tick();
      chk("arst pre pulse", 32'(if10.pulse), ref_bit(5, 5, 10));
      chk("arst pre busy", 32'(if10.busy), 1);
      #1 rst_n = 1'b0;
      #1;
      chk("arst pulse", 32'(if10.pulse), 0);
      chk("arst fs", 32'(if10.frame_start), 0);
      chk("arst busy", 32'(if10.busy), 0);
      chk("arst ready", 32'(if10.code_ready), 1);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      frame10(4, 4, "post_rst");

      // loopback at N=1000: bench-side counter decodes each frame
      for (int f = 0; f < 50; f++) begin
         if (f == 0)      code = 1000;
         else if (f == 1) code = 0;
         else if (f == 2) code = 1023;
         else             code = int'($urandom_range(0, 1000));
         cq = (code > 1000) ? 1000 : code;
         if1k.code = 10'(code);
         if1k.code_valid = 1'b1;
         tick();
         if1k.code_valid = 1'b0;
         chk($sformatf("lb%0d fs", f), 32'(if1k.frame_start), 1);
         ones = 0;
         mism = 0;
         for (int k = 0; k < 1000; k++) begin
            ones += int'(if1k.pulse);
            if (if1k.pulse !== 1'(ref_bit(k, cq, 1000))) mism++;
            tick();
         end
         chk($sformatf("lb%0d ones", f), ones, cq);
         chk($sformatf("lb%0d pattern_mism", f), mism, 0);
         chk($sformatf("lb%0d busy_after", f), 32'(if1k.busy), 0);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
